// File: rtl/sst_sequencer_pkg.sv
// Shared types for the save-state sequencer: FSM states, index address, default window size.
// Pure declarations; no logic, no latency, no flow control.
// Imported by the sequencer top; the m2 generator stays package-free so it can be reused.
package sst_pkg;

    localparam int         REG_CNT_DEF  = 128;
    localparam logic [7:0] SST_IDX_ADDR = 8'd127;

    typedef enum logic [3:0] {
        IDLE,
        SV_ADDR,
        SV_SMP,
        LD_FETCH,
        LD_WAIT,
        LD_M2H,
        LD_M2L,
        FIN,
        CHK_FETCH,
        CHK_WAIT
    } sst_state_t;

    // The bus is driven in every state between the start and the closing FIN.
    function automatic logic is_active(sst_state_t s);
        return (s != IDLE) && (s != FIN);
    endfunction

endpackage

// File: rtl/sst_sequencer_if.sv
// SST register bus plus save buffer port; master = sequencer, slave = mapper/buffer side.
// Wires only; sst_di is combinational from sst_addr, buf_rdat lags buf_addr by one clk.
// No backpressure: the responder must keep up with the strobes as they come.
interface sst_sequencer_if;
    logic       sst_act;
    logic [7:0] sst_addr;
    logic       sst_we_reg;
    logic [7:0] sst_dato;
    logic       sst_m2;
    logic [7:0] sst_di;
    logic [7:0] buf_addr;
    logic       buf_we;
    logic [7:0] buf_wdat;
    logic [7:0] buf_rdat;

    modport master (
        output sst_act, sst_addr, sst_we_reg, sst_dato, sst_m2,
        output buf_addr, buf_we, buf_wdat,
        input  sst_di, buf_rdat
    );

    modport slave (
        input  sst_act, sst_addr, sst_we_reg, sst_dato, sst_m2,
        input  buf_addr, buf_we, buf_wdat,
        output sst_di, buf_rdat
    );
endinterface

// File: rtl/sst_sequencer_m2_gen.sv
// Half-period counter generating an m2 pulse (high phase then low phase) and a phase_end strobe.
// Each phase lasts HALF clks; m2 goes high the cycle en rises.
// No backpressure: dropping en resets the generator to the start of a high phase.
module sst_m2_gen #(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic m2,
    output logic phase_end
);
    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] hcnt_q;
    logic          phase_q;

    assign phase_end = en && (hcnt_q == CW'(HALF - 1));
    assign m2        = en && !phase_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q  <= '0;
            phase_q <= 1'b0;
        end else if (!en) begin
            hcnt_q  <= '0;
            phase_q <= 1'b0;
        end else if (phase_end) begin
            hcnt_q  <= '0;
            phase_q <= !phase_q;
        end else begin
            hcnt_q  <= hcnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/sst_sequencer.sv
// SST bus master: copies the mapper register window to the buffer (save) or back (load).
// Save costs REG_CNT*(SETTLE+1) clks, load REG_CNT*(2+2*M2_HALF) clks; done one clk after.
// No backpressure; starts are ignored while busy. SST_SEQ_IDX_CHECK_EN adds the mapper-index check.
module sst_sequencer
    import sst_pkg::*;
#(
    parameter int REG_CNT = REG_CNT_DEF,
    parameter int M2_HALF = 2,
    parameter int SETTLE  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_save,
    input  logic               start_load,
    input  logic [7:0]         map_idx,
    output logic               busy,
    output logic               done,
    output logic               err,
    sst_sequencer_if.master    bus
);
    localparam logic [7:0] LAST_ADDR   = 8'(REG_CNT - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    sst_state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic [7:0] dato_q, dato_d;
    logic       m2_en;
    logic       m2;
    logic       phase_end;
    logic       act;

`ifdef SST_SEQ_IDX_CHECK_EN
    logic err_q, err_d;
    assign err = err_q;
`else
    logic map_idx_unused;
    assign map_idx_unused = ^map_idx;
    assign err = 1'b0;
`endif

    sst_m2_gen #(.HALF(M2_HALF)) u_m2_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (m2_en),
        .m2        (m2),
        .phase_end (phase_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            dato_q  <= '0;
`ifdef SST_SEQ_IDX_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            dato_q  <= dato_d;
`ifdef SST_SEQ_IDX_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        dato_d  = dato_q;
`ifdef SST_SEQ_IDX_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_save || start_load) begin
                    cnt_d  = '0;
                    wcnt_d = '0;
`ifdef SST_SEQ_IDX_CHECK_EN
                    err_d  = 1'b0;
                    state_d = start_save ? SV_ADDR : CHK_FETCH;
`else
                    state_d = start_save ? SV_ADDR : LD_FETCH;
`endif
                end
            end
            SV_ADDR: begin
                if (wcnt_q == SETTLE_LAST) begin
                    wcnt_d  = '0;
                    state_d = SV_SMP;
                end else begin
                    wcnt_d  = wcnt_q + 8'd1;
                end
            end
            // Terminal compare precedes the increment so cnt never wraps.
            SV_SMP: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = FIN;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = SV_ADDR;
                end
            end
            LD_FETCH: state_d = LD_WAIT;
            LD_WAIT: begin
                dato_d  = bus.buf_rdat;
                state_d = LD_M2H;
            end
            LD_M2H: begin
                if (phase_end) state_d = LD_M2L;
            end
            LD_M2L: begin
                if (phase_end) begin
                    if (cnt_q == LAST_ADDR) begin
                        state_d = FIN;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        state_d = LD_FETCH;
                    end
                end
            end
`ifdef SST_SEQ_IDX_CHECK_EN
            CHK_FETCH: state_d = CHK_WAIT;
            CHK_WAIT: begin
                if (bus.buf_rdat != map_idx) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    state_d = LD_FETCH;
                end
            end
`endif
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // All outputs decode from reset-cleared registers, so they drop as soon as rst_n falls.
    assign act   = is_active(state_q);
    assign busy  = act;
    assign done  = (state_q == FIN);
    assign m2_en = (state_q == LD_M2H) || (state_q == LD_M2L);

    assign bus.sst_act    = act;
    assign bus.sst_addr   = act ? cnt_q : 8'd0;
    assign bus.sst_we_reg = m2_en;
    assign bus.sst_dato   = dato_q;
    assign bus.sst_m2     = m2;
    assign bus.buf_we     = (state_q == SV_SMP);
    assign bus.buf_wdat   = (state_q == SV_SMP) ? bus.sst_di : 8'd0;

    always_comb begin
        bus.buf_addr = 8'd0;
        case (state_q)
            SV_SMP, LD_FETCH, LD_WAIT: bus.buf_addr = cnt_q;
            CHK_FETCH, CHK_WAIT:       bus.buf_addr = SST_IDX_ADDR;
            default:                   bus.buf_addr = 8'd0;
        endcase
    end
endmodule

// File: tb/tb_sst_sequencer.sv
// Directed bench for sst_sequencer: mapper stub, buffer model and queue scoreboards.
// Define SST_SEQ_IDX_CHECK_EN for both bench and RTL to cover the index-check build.
module tb_sst_sequencer;
    import sst_pkg::*;

    localparam int RC  = 128;
    localparam int M2H = 2;
    localparam int SET = 1;
    localparam int SV_LAT = RC * (SET + 1);
`ifdef SST_SEQ_IDX_CHECK_EN
    localparam int LD_LAT = RC * (2 + 2 * M2H) + 2;
`else
    localparam int LD_LAT = RC * (2 + 2 * M2H);
`endif
    localparam int LD_WE = RC * 2 * M2H;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_save = 1'b0;
    logic       start_load = 1'b0;
    logic [7:0] map_idx = 8'd0;
    logic       busy, done, err;

    sst_sequencer_if bus();

    sst_sequencer #(.REG_CNT(RC), .M2_HALF(M2H), .SETTLE(SET)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_save (start_save),
        .start_load (start_load),
        .map_idx    (map_idx),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] bmem [256];
    logic [7:0] regs [256];
    bit         stub_mode = 1'b0;   // 0: pattern stub A (addr^5A), 1: writable stub B

    ent_t sv_q[$];
    ent_t ld_q[$];
    ent_t sv_e, ld_e;

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int m2_falls = 0;
    int we_cycles = 0;

    assign bus.sst_di = stub_mode ? regs[bus.sst_addr] : (bus.sst_addr ^ 8'h5A);

    always @(posedge clk) begin
        if (bus.buf_we === 1'b1) bmem[bus.buf_addr] <= bus.buf_wdat;
        bus.buf_rdat <= bmem[bus.buf_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (bus.sst_we_reg === 1'b1) we_cycles++;
        if (bus.buf_we === 1'b1) begin
            if (sv_q.size() == 0) begin
                chk("buf_we_unexpected", 64'd1, 64'd0);
            end else begin
                sv_e = sv_q.pop_front();
                chk("save_wr", {bus.buf_addr, bus.buf_wdat}, {sv_e.a, sv_e.d});
            end
        end
    end

    // Mapper side: commit on the falling m2 edge while act and we_reg are high.
    always @(negedge bus.sst_m2) begin
        #1;
        if (bus.sst_act === 1'b1 && bus.sst_we_reg === 1'b1) begin
            m2_falls++;
            regs[bus.sst_addr] = bus.sst_dato;
            if (ld_q.size() == 0) begin
                chk("m2_unexpected", 64'd1, 64'd0);
            end else begin
                ld_e = ld_q.pop_front();
                chk("load_wr", {bus.sst_addr, bus.sst_dato}, {ld_e.a, ld_e.d});
            end
        end
    end

    function automatic logic [63:0] all_outs();
        return {busy, done, err, bus.sst_act, bus.sst_addr, bus.sst_we_reg, bus.sst_dato,
                bus.sst_m2, bus.buf_addr, bus.buf_we, bus.buf_wdat};
    endfunction

    task automatic run_op(input string tag, input bit sv, input bit ld, input int exp_lat,
                          input int exp_we, input int inject_at);
        int lat, busy_low, d0, w0;
        bit seen;
        d0 = done_cnt; w0 = we_cycles; lat = 0; busy_low = 0; seen = 1'b0;
        @(negedge clk);
        start_save = sv; start_load = ld;
        @(negedge clk);
        start_save = 1'b0; start_load = 1'b0;
        for (int i = 0; i < exp_lat + 100 && !seen; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = i;
            end else begin
                if (busy !== 1'b1) busy_low++;
                if (inject_at > 0) start_load = (i == inject_at);
                @(negedge clk);
            end
        end
        start_load = 1'b0;
        chk({tag, "_latency"}, seen ? 64'(lat) : '1, 64'(exp_lat));
        chk({tag, "_busy_low"}, 64'(busy_low), 64'd0);
        repeat (5) @(negedge clk);
        chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, "_we_cycles"}, 64'(we_cycles - w0), 64'(exp_we));
        chk({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
    endtask

    task automatic push_save();
        for (int i = 0; i < RC; i++) sv_q.push_back({8'(i), 8'(i) ^ 8'h5A});
    endtask

    task automatic push_load();
        for (int i = 0; i < RC; i++) ld_q.push_back({8'(i), bmem[i]});
    endtask

    task automatic clear_regs();
        for (int i = 0; i < 256; i++) regs[i] = 8'd0;
    endtask

    function automatic int regs_mismatch();
        int n = 0;
        for (int i = 0; i < RC; i++) if (regs[i] !== bmem[i]) n++;
        return n;
    endfunction

    initial begin
        int m0, d0, bad;
        bit found;
        for (int i = 0; i < 256; i++) bmem[i] = 8'd0;
        clear_regs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;

        // Save from pattern stub A.
        stub_mode = 1'b0;
        push_save();
        run_op("save", 1'b1, 1'b0, SV_LAT, 0, 0);
        chk("save_queue_empty", 64'(sv_q.size()), 64'd0);
        bad = 0;
        for (int i = 0; i < RC; i++) if (bmem[i] !== (8'(i) ^ 8'h5A)) bad++;
        chk("save_buffer", 64'(bad), 64'd0);

        // Round trip into blank stub B.
        stub_mode = 1'b1;
        clear_regs();
        map_idx = bmem[127];
        push_load();
        run_op("roundtrip", 1'b0, 1'b1, LD_LAT, LD_WE, 0);
        chk("roundtrip_regs", 64'(regs_mismatch()), 64'd0);
        chk("roundtrip_err", {63'd0, err}, 64'd0);

        // Load buffer[i]=i.
        for (int i = 0; i < 256; i++) bmem[i] = 8'(i);
        clear_regs();
        map_idx = 8'd127;
        m0 = m2_falls;
        push_load();
        run_op("load", 1'b0, 1'b1, LD_LAT, LD_WE, 0);
        chk("load_m2_edges", 64'(m2_falls - m0), 64'(RC));
        chk("load_queue_empty", 64'(ld_q.size()), 64'd0);
        chk("load_regs", 64'(regs_mismatch()), 64'd0);

        // Simultaneous starts, then a start while busy.
        stub_mode = 1'b0;
        push_save();
        run_op("both", 1'b1, 1'b1, SV_LAT, 0, 50);
        chk("both_save_queue", 64'(sv_q.size()), 64'd0);

        // Reset in the middle of a load at address 40.
        stub_mode = 1'b1;
        clear_regs();
        push_load();
        @(negedge clk);
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (bus.sst_addr === 8'd40 && bus.sst_m2 === 1'b1) found = 1'b1;
        end
        chk("rst_reach_addr40", {63'd0, found}, 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_outputs", all_outs(), 64'd0);
        d0 = done_cnt;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
        ld_q.delete();
        clear_regs();
        push_load();
        run_op("reload", 1'b0, 1'b1, LD_LAT, LD_WE, 0);
        chk("reload_regs", 64'(regs_mismatch()), 64'd0);
        chk("reload_queue_empty", 64'(ld_q.size()), 64'd0);

`ifdef SST_SEQ_IDX_CHECK_EN
        bmem[127] = 8'd180;
        map_idx = 8'd2;
        m0 = m2_falls;
        run_op("idx_bad", 1'b0, 1'b1, 2, 0, 0);
        chk("idx_bad_err", {63'd0, err}, 64'd1);
        chk("idx_bad_m2_edges", 64'(m2_falls - m0), 64'd0);
        map_idx = 8'd180;
        clear_regs();
        push_load();
        run_op("idx_ok", 1'b0, 1'b1, LD_LAT, LD_WE, 0);
        chk("idx_ok_err", {63'd0, err}, 64'd0);
        chk("idx_ok_regs", 64'(regs_mismatch()), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sst_sequencer.md
Name: sst_sequencer

Overview:
- Initiator/master of the mapper save-state (SST) register bus.
- Every mapper is a responder on this bus: it returns register bytes on sst_di for a given address, and loads sst_dato on the falling edge of m2 while act and we_reg are high.
- This block walks the mapper register window and copies it to a byte buffer (save), or copies the buffer back into the mapper (load).
- Sits between the menu/host control logic and the active mapper; the CPU is halted while it is busy.

Parameters:
- REG_CNT, 128: number of SST addresses walked, 0..REG_CNT-1. Address 127 holds the mapper index.
- M2_HALF, 2: clk cycles per m2 half-period during a load write pulse (minimum 1).
- SETTLE, 1: clk cycles between driving the address and sampling sst_di on save (minimum 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_save  in  1  single-cycle request: mapper to buffer.
- start_load  in  1  single-cycle request: buffer to mapper.
- map_idx  in  8  current mapper index, used for the load check.
- busy  out  1  high from the cycle after a start until done.
- done  out  1  single-cycle pulse at the end of an operation.
- err  out  1  sticky index-mismatch flag; cleared by the next start.
- sst_act  out  1  SST bus active.
- sst_addr  out  8  SST register address.
- sst_we_reg  out  1  write-enable qualifier to the mapper.
- sst_dato  out  8  write data to the mapper.
- sst_m2  out  1  m2 substitute; the mapper commits on its falling edge.
- sst_di  in  8  read data from the mapper (combinational from sst_addr).
- buf_addr  out  8  buffer address.
- buf_we  out  1  buffer write strobe.
- buf_wdat  out  8  buffer write data.
- buf_rdat  in  8  buffer read data, valid 1 clk after buf_addr.

Behaviour:
- Reset values: all outputs 0, state IDLE.
- States: IDLE, SV_ADDR, SV_SMP, LD_FETCH, LD_WAIT, LD_M2H, LD_M2L, FIN.
- IDLE:
  - start_save enters SV_ADDR; start_load enters LD_FETCH (or CHK_FETCH when the optional feature is compiled in).
  - Both starts in the same cycle: save wins.
  - Starts are ignored while busy.
  - A start clears err and sets the address counter to 0.
- sst_act is high in every non-IDLE, non-FIN state.
- Save:
  - SV_ADDR drives sst_addr=cnt and holds for SETTLE clks.
  - SV_SMP issues one buf_we with buf_addr=cnt and buf_wdat=sst_di.
  - Then cnt increments and the block returns to SV_ADDR, or goes to FIN when cnt==REG_CNT-1.
  - Cost: REG_CNT*(SETTLE+1) clks.
- Load:
  - LD_FETCH drives buf_addr=cnt.
  - LD_WAIT latches buf_rdat into sst_dato.
  - LD_M2H drives sst_m2=1, sst_we_reg=1 and sst_addr=cnt for M2_HALF clks.
  - LD_M2L drives sst_m2=0 for M2_HALF clks, holding addr, dato and we_reg through the low phase.
  - Then cnt increments, or the block goes to FIN at the last address.
  - Exactly one falling sst_m2 edge per address.
  - sst_we_reg is low outside LD_M2H/LD_M2L.
- FIN: busy=0, done=1 for one clk, sst_act=0, sst_m2=0, then IDLE.
- cnt is 8 bits and never wraps; the terminal compare is made before the increment.
- Reset mid-operation:
  - Outputs drop immediately (asynchronously).
  - A partial load leaves the mapper registers partially written; upper layers retry.
  - No done pulse is produced.

Optional Feature:
- Macro SST_SEQ_IDX_CHECK_EN.
- With the macro defined, load first reads buffer address 127 (CHK_FETCH, CHK_WAIT).
  - If buf_rdat != map_idx: set err=1, skip all writes, go to FIN (done still pulses).
  - If they match: continue with LD_FETCH at cnt=0.
- Without the macro, no check is made; err is tied to 0.

Decomposition:
- Shared package sst_pkg holds:
  - the state enum;
  - SST_IDX_ADDR=8'd127;
  - default REG_CNT.
- One sub-module, sst_m2_gen: a half-period counter producing sst_m2 and a phase_end strobe. It is reusable by other halted-CPU engines.

Test Plan:
1. Save with a mapper stub returning addr^8'h5A, REG_CNT=128, SETTLE=1 -> buffer holds 128 matching bytes, done after 256 clks, busy high throughout.
2. Load with buffer[i]=i, M2_HALF=2 -> stub sees 128 falling sst_m2 edges; data at each edge = addr; we_reg never high outside a pulse; done after 128*6 clks.
3. start_save and start_load asserted together, then a start while busy -> a save runs; the second start is ignored and no extra done pulse appears.
4. rst_n low during load at addr 40 -> all outputs 0 asynchronously, no done pulse; a fresh load afterwards completes normally.
5. SST_SEQ_IDX_CHECK_EN defined:
   - buffer[127]=8'd180, map_idx=8'd180 -> full load, err=0;
   - map_idx=8'd2 -> zero m2 edges, err=1, done pulses once.
6. Round trip: save from stub A, load into a blank stub B -> B's registers equal A's at all 128 addresses.
